// File: rtl/tt_sweep_ctrl_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweep controller.
//   state_t          - controller FSM states
//   N_IN / N_ROWS    - circuit input count and number of truth-table rows
//   ROW_W / MCNT_W   - row counter width and mismatch counter width
//   EXPECTED_DEFAULT - default expected truth table (bit r = output for row r)
package tt_sweep_pkg;

  localparam int N_IN   = 4;
  localparam int N_ROWS = 16;
  localparam int ROW_W  = 4;
  // 5 bits so that a fully inverted table (16 mismatches) is representable
  localparam int MCNT_W = 5;

  localparam logic [N_ROWS-1:0] EXPECTED_DEFAULT = 16'hC248;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: bundles the host control/status signals and the
// circuit-under-test row/output pair of one sweep controller.
//   start, abort  - host requests
//   busy, done    - sweep status; done is a one-cycle completion pulse
//   pass, tt_word, mismatch_cnt - sweep result, held until the next start
//   dut_in        - row applied to the circuit
//   dut_out       - circuit output returned to the controller
// master: host + circuit side.  slave: the controller.
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;

  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_ROWS-1:0]   tt_word;
  logic [MCNT_W-1:0]   mismatch_cnt;
  logic [N_IN-1:0]     dut_in;
  logic                dut_out;

  modport master (
    output start, abort, dut_out,
    input  busy, done, pass, tt_word, mismatch_cnt, dut_in
  );

  modport slave (
    input  start, abort, dut_out,
    output busy, done, pass, tt_word, mismatch_cnt, dut_in
  );

endinterface

// File: rtl/tt_sweep_ctrl_popcount16.sv
// tt_popcount16: combinational population count of a 16-bit vector.
//   vec - input word
//   cnt - number of set bits, 0..16
module tt_popcount16
  import tt_sweep_pkg::*;
(
  input  logic [N_ROWS-1:0] vec,
  output logic [MCNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      cnt = cnt + MCNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: applies all 16 rows to a 4-input combinational circuit,
// waits SETTLE cycles per row, samples the output into a truth-table word
// and compares it with EXPECTED at the end of the sweep.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - tt_sweep_ctrl_if.slave: start/abort in, busy/done/pass/tt_word/
//          mismatch_cnt out, dut_in out to the circuit, dut_out back
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; results of the last sweep held
// ST_SETTLE | dut_in holds the current row for SETTLE cycles
// ST_SAMPLE | dut_out captured into tt_word[row]; advance or finish
// ST_DONE   | one-cycle done pulse; pass/mismatch_cnt already valid
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned       SETTLE   = 2,
  parameter logic [N_ROWS-1:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  tt_sweep_ctrl_if.slave  bus
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(N_ROWS - 1);

  state_t              state_q, state_nxt;
  logic [ROW_W-1:0]    row_q;
  logic [7:0]          settle_cnt_q;
  logic [N_ROWS-1:0]   tt_word_q;
  logic [N_ROWS-1:0]   tt_word_nxt;
  logic                pass_q;
  logic [MCNT_W-1:0]   mcnt_q;
  logic [MCNT_W-1:0]   mcnt_final;
  logic                start_ok;

  assign start_ok = bus.start && !bus.abort;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.abort)                        state_nxt = ST_IDLE;
        else if (settle_cnt_q == SETTLE_LAST) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.abort)              state_nxt = ST_IDLE;
        else if (row_q == ROW_LAST) state_nxt = ST_DONE;
        else                        state_nxt = ST_SETTLE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.busy = (state_q != ST_IDLE);
    bus.done = (state_q == ST_DONE);
  end

  // truth-table word including the bit being sampled this cycle, so the
  // final compare can be registered on the same edge that enters ST_DONE
  always_comb begin
    tt_word_nxt        = tt_word_q;
    tt_word_nxt[row_q] = bus.dut_out;
  end

  tt_popcount16 u_popcount (
    .vec (tt_word_nxt ^ EXPECTED),
    .cnt (mcnt_final)
  );

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      settle_cnt_q <= '0;
      tt_word_q    <= '0;
      pass_q       <= 1'b0;
      mcnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            row_q        <= '0;
            settle_cnt_q <= '0;
            tt_word_q    <= '0;
            pass_q       <= 1'b0;
            mcnt_q       <= '0;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            row_q        <= '0;
            settle_cnt_q <= '0;
            pass_q       <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        ST_SAMPLE: begin
          if (bus.abort) begin
            // the sample of an aborted row is discarded
            row_q        <= '0;
            settle_cnt_q <= '0;
            pass_q       <= 1'b0;
          end else begin
            tt_word_q <= tt_word_nxt;
            if (row_q == ROW_LAST) begin
              pass_q <= (tt_word_nxt == EXPECTED);
              mcnt_q <= mcnt_final;
            end else begin
              row_q        <= row_q + 1'b1;
              settle_cnt_q <= '0;
            end
          end
        end
        ST_DONE: begin
          // park the circuit input at row 0 while idle
          row_q <= '0;
          if (bus.abort) pass_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in       = row_q;
  assign bus.tt_word      = tt_word_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_ctrl_if bus_a ();
  tt_sweep_ctrl_if bus_b ();

  tt_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hC248)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  tt_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'hC248)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // circuit models
  logic [15:0] exp_word  = 16'hC248;
  logic [15:0] flip_mask = 16'h0000;
  logic        stuck_en  = 1'b0;
  logic        stuck_val = 1'b0;
  int          dly_b     = 1;
  logic        d1 = 1'b0;
  logic        d2 = 1'b0;

  assign bus_a.dut_out = stuck_en ? stuck_val
                                  : (exp_word[bus_a.dut_in] ^ flip_mask[bus_a.dut_in]);

  always @(posedge clk) begin
    d1 <= exp_word[bus_b.dut_in];
    d2 <= d1;
  end
  assign bus_b.dut_out = (dly_b == 1) ? d1 : d2;

  // scoreboard
  typedef struct {
    logic [15:0] word;
    logic        pass;
    logic [4:0]  mcnt;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   vectors    = 0;
  int   miscompares = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.done === 1'b1) begin
      done_cnt_a++;
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_tt_word",  32'(bus_a.tt_word),      32'(e_a.word));
        check("a_pass",     32'(bus_a.pass),         32'(e_a.pass));
        check("a_mcnt",     32'(bus_a.mismatch_cnt), 32'(e_a.mcnt));
        check("a_done_cyc", 32'(cyc),                32'(e_a.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.done === 1'b1) begin
      done_cnt_b++;
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_tt_word",  32'(bus_b.tt_word),      32'(e_b.word));
        check("b_pass",     32'(bus_b.pass),         32'(e_b.pass));
        check("b_mcnt",     32'(bus_b.mismatch_cnt), 32'(e_b.mcnt));
        check("b_done_cyc", 32'(cyc),                32'(e_b.cyc));
      end
    end
  end

  // reference: what a sweep of circuit A must capture, row by row
  function automatic logic [15:0] model_word_a();
    logic [15:0] w;
    for (int r = 0; r < 16; r++)
      w[r] = stuck_en ? stuck_val : (exp_word[r] ^ flip_mask[r]);
    return w;
  endfunction

  // reference for circuit B (SETTLE=1, output delayed by d cycles):
  // row r is sampled in sweep cycle (r+1)*2; the output then reflects the
  // row applied d cycles earlier, and row 0 is applied before the sweep.
  function automatic logic [15:0] model_word_b(input int d);
    logic [15:0] w;
    int c, src, rs;
    for (int r = 0; r < 16; r++) begin
      c   = (r + 1) * 2;
      src = c - d;
      rs  = (src < 1) ? 0 : (src - 1) / 2;
      w[r] = exp_word[rs];
    end
    return w;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy"},    32'(bus_a.busy),         32'd0);
    check({tag, "_done"},    32'(bus_a.done),         32'd0);
    check({tag, "_pass"},    32'(bus_a.pass),         32'd0);
    check({tag, "_tt_word"}, 32'(bus_a.tt_word),      32'd0);
    check({tag, "_mcnt"},    32'(bus_a.mismatch_cnt), 32'd0);
    check({tag, "_dut_in"},  32'(bus_a.dut_in),       32'd0);
  endtask

  // one sweep on A; negative cycle numbers disable the corresponding event
  task automatic run_a(input int abort_at, input int restart_at, input int rst_at, input bit trace);
    logic [15:0] w, part;
    exp_t        e;
    int          t0, k, dc0;
    w = model_word_a();
    dc0 = done_cnt_a;
    @(negedge clk);
    t0 = cyc;
    if (abort_at < 0 && rst_at < 0) begin
      e.word = w;
      e.pass = (w == exp_word);
      e.mcnt = 5'($countones(w ^ exp_word));
      e.cyc  = t0 + 49;
      q_a.push_back(e);
    end
    for (int n = 0; n <= 54; n++) begin
      if (n > 0) @(negedge clk);
      bus_a.start = (n == 0) || (n == restart_at);
      bus_a.abort = (n == abort_at);
      rst         = (n == rst_at);
      if (trace) begin
        check("busy_trace", 32'(bus_a.busy), 32'((n >= 1) && (n <= 49)));
        if (n >= 1 && n <= 48)
          check("dut_in_trace", 32'(bus_a.dut_in), 32'((n - 1) / 3));
      end
      if (abort_at >= 0 && n == abort_at + 1) begin
        k    = (abort_at - 1) / 3;
        part = w & ((16'd1 << k) - 16'd1);
        check("abort_busy",    32'(bus_a.busy),    32'd0);
        check("abort_done",    32'(bus_a.done),    32'd0);
        check("abort_pass",    32'(bus_a.pass),    32'd0);
        check("abort_dut_in",  32'(bus_a.dut_in),  32'd0);
        check("abort_tt_word", 32'(bus_a.tt_word), 32'(part));
      end
      if (rst_at >= 0 && n == rst_at + 1) check_reset("midrst");
    end
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    rst         = 1'b0;
    if (abort_at >= 0 || rst_at >= 0)
      check("no_done_after_stop", 32'(done_cnt_a), 32'(dc0));
  endtask

  task automatic run_b(input int d);
    exp_t e;
    logic [15:0] w;
    dly_b = d;
    repeat (4) @(negedge clk);
    w = model_word_b(d);
    bus_b.start = 1'b1;
    e.word = w;
    e.pass = (w == exp_word);
    e.mcnt = 5'($countones(w ^ exp_word));
    e.cyc  = cyc + 33;
    q_b.push_back(e);
    @(negedge clk);
    bus_b.start = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    check("reset_b_busy", 32'(bus_b.busy), 32'd0);

    // golden circuit with full busy/dut_in trace
    run_a(-1, -1, -1, 1'b1);
    // stuck-at faults and a single inverted row
    stuck_en = 1'b1; stuck_val = 1'b0;
    run_a(-1, -1, -1, 1'b0);
    stuck_val = 1'b1;
    run_a(-1, -1, -1, 1'b0);
    stuck_en = 1'b0;
    flip_mask = 16'h0080;
    run_a(-1, -1, -1, 1'b1);
    // random fault patterns
    for (int i = 0; i < 6; i++) begin
      flip_mask = 16'($urandom) & 16'($urandom);
      run_a(-1, -1, -1, 1'b0);
    end
    flip_mask = 16'h0000;

    // start re-pulsed mid-sweep is ignored
    run_a(-1, 10, -1, 1'b0);
    // abort, then a clean sweep
    run_a(20, -1, -1, 1'b0);
    run_a(-1, -1, -1, 1'b0);

    // abort and start together in idle: no sweep
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    check("abort_start_busy", 32'(bus_a.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_start_busy_later", 32'(bus_a.busy), 32'd0);

    // synchronous reset mid-sweep
    run_a(-1, -1, 30, 1'b0);

    // delayed-output circuit with SETTLE=1
    run_b(1);
    run_b(2);

    repeat (5) @(negedge clk);
    check("a_missing_done", 32'(q_a.size()), 32'd0);
    check("b_missing_done", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
